// File: rtl/wr_burst_fifo.sv
// Single-clock FIFO with registered read data, burst-ready and programmable threshold flags.
// All occupancy flags decode from the registered word count, so they change one edge after the access.
module wr_burst_fifo #(
   parameter int DATA_WIDTH        = 64,
   parameter int ADDR_WIDTH        = 10,
   parameter int WRITE_BURST       = 8,
   parameter int PROG_FULL_THRESH  = 1000,
   parameter int PROG_EMPTY_THRESH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_fifo,
   input  logic                  rd_fifo,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  dout_vd,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  prog_full,
   output logic                  prog_empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  burst_rdy,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_FULL   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] CNT_AFULL  = (ADDR_WIDTH+1)'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] CNT_PFULL  = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
   localparam logic [ADDR_WIDTH:0] CNT_PEMPTY = (ADDR_WIDTH+1)'(PROG_EMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] CNT_BURST  = (ADDR_WIDTH+1)'(WRITE_BURST);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Gating with the flags gives write-wins on empty and read-wins on full for free.
   assign wr_ok = wr_fifo & ~full;
   assign rd_ok = rd_fifo & ~empty;

   // Storage is not cleared on reset; only the pointers and count are.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
         data_out   <= '0;
         dout_vd    <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         overflow  <= wr_fifo & full;
         underflow <= rd_fifo & empty;
         dout_vd   <= rd_ok;
         if (wr_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   data_count <= data_count + CNT_ONE;
            2'b01:   data_count <= data_count - CNT_ONE;
            default: data_count <= data_count;
         endcase
      end
   end

   assign full         = (data_count == CNT_FULL);
   assign empty        = (data_count == '0);
   assign almost_full  = (data_count >= CNT_AFULL);
   assign almost_empty = (data_count <= CNT_ONE);
   assign prog_full    = (data_count >= CNT_PFULL);
   assign prog_empty   = (data_count <= CNT_PEMPTY);
   assign burst_rdy    = (data_count >= CNT_BURST);

endmodule

// File: tb/tb_wr_burst_fifo.sv
// Directed bench for wr_burst_fifo: a count model plus a data queue predicts every output each cycle.
module tb_wr_burst_fifo;

   localparam int DW    = 64;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;
   localparam int PFT   = 1000;
   localparam int PET   = 8;
   localparam int WB    = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          wr_fifo = 1'b0;
   logic          rd_fifo = 1'b0;
   logic [DW-1:0] data_out;
   logic          dout_vd;
   logic          full, empty, almost_full, almost_empty;
   logic          prog_full, prog_empty;
   logic [AW:0]   data_count;
   logic          burst_rdy, overflow, underflow;

   int n_checks = 0;
   int n_errors = 0;

   int            mcount = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_dout = '0;
   logic          exp_vd = 1'b0;
   logic          exp_ovf = 1'b0;
   logic          exp_udf = 1'b0;

   wr_burst_fifo #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_BURST(WB),
      .PROG_FULL_THRESH(PFT), .PROG_EMPTY_THRESH(PET)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .wr_fifo(wr_fifo), .rd_fifo(rd_fifo),
      .data_out(data_out), .dout_vd(dout_vd), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .prog_full(prog_full), .prog_empty(prog_empty), .data_count(data_count),
      .burst_rdy(burst_rdy), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("dout_vd", 64'(dout_vd), 64'(exp_vd));
      chk("data_out", data_out, exp_dout);
      chk("data_count", 64'(data_count), 64'(mcount));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("underflow", 64'(underflow), 64'(exp_udf));
      chk("full", 64'(full), 64'(mcount == DEPTH));
      chk("empty", 64'(empty), 64'(mcount == 0));
      chk("almost_full", 64'(almost_full), 64'(mcount >= DEPTH - 1));
      chk("almost_empty", 64'(almost_empty), 64'(mcount <= 1));
      chk("prog_full", 64'(prog_full), 64'(mcount >= PFT));
      chk("prog_empty", 64'(prog_empty), 64'(mcount <= PET));
      chk("burst_rdy", 64'(burst_rdy), 64'(mcount >= WB));
   endtask

   // One clock: drive, predict from the pre-edge model state, then sample 1 ns after the edge.
   task automatic cycle(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
      logic wa, ra;
      reset   = rst;
      wr_fifo = w;
      rd_fifo = r;
      data_in = d;
      if (rst) begin
         mcount = 0;
         exp_q.delete();
         exp_dout = '0;
         exp_vd   = 1'b0;
         exp_ovf  = 1'b0;
         exp_udf  = 1'b0;
      end else begin
         wa      = w && (mcount != DEPTH);
         ra      = r && (mcount != 0);
         exp_ovf = w && (mcount == DEPTH);
         exp_udf = r && (mcount == 0);
         exp_vd  = ra;
         if (ra) exp_dout = exp_q.pop_front();
         if (wa) exp_q.push_back(d);
         mcount = mcount + (wa ? 1 : 0) - (ra ? 1 : 0);
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      cycle(1, 1, 1, 64'hDEAD);
      cycle(1, 0, 0, '0);
      chk("reset_count", 64'(data_count), 64'd0);
      chk("reset_empty", 64'(empty), 64'd1);

      for (int i = 1; i <= 8; i++) cycle(0, 1, 0, DW'(i));
      chk("burst_rdy_at_8", 64'(burst_rdy), 64'd1);
      chk("prog_empty_at_8", 64'(prog_empty), 64'd1);
      cycle(0, 1, 0, 64'h9);
      chk("prog_empty_at_9", 64'(prog_empty), 64'd0);
      for (int i = 0; i < 9; i++) cycle(0, 0, 1, '0);
      cycle(0, 0, 0, '0);
      chk("empty_after_drain", 64'(empty), 64'd1);

      cycle(0, 0, 1, '0);
      chk("underflow_alone", 64'(underflow), 64'd1);
      cycle(0, 1, 1, 64'hA5);
      chk("underflow_with_wr", 64'(underflow), 64'd1);
      chk("count_after_wr_on_empty", 64'(data_count), 64'd1);
      cycle(0, 0, 1, '0);
      chk("read_a5", data_out, 64'hA5);
      cycle(0, 0, 0, '0);

      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, rnd64());
      chk("full_at_1024", 64'(full), 64'd1);
      cycle(0, 1, 0, rnd64());
      chk("overflow_pulse", 64'(overflow), 64'd1);
      chk("count_stays_full", 64'(data_count), 64'(DEPTH));
      cycle(0, 0, 0, '0);
      chk("overflow_one_cycle", 64'(overflow), 64'd0);
      cycle(0, 1, 1, rnd64());
      chk("rdwr_on_full", 64'(data_count), 64'(DEPTH - 1));

      while (mcount > 512) cycle(0, 0, 1, '0);
      for (int i = 0; i < 3000; i++) cycle(0, 1, 1, rnd64());
      chk("stream_count", 64'(data_count), 64'd512);

      while (mcount > 300) cycle(0, 0, 1, '0);
      cycle(1, 1, 0, rnd64());
      chk("midreset_count", 64'(data_count), 64'd0);
      chk("midreset_vd", 64'(dout_vd), 64'd0);
      cycle(0, 0, 0, '0);
      cycle(0, 1, 0, 64'h77);
      cycle(0, 0, 1, '0);
      chk("post_reset_read", data_out, 64'h77);
      cycle(0, 0, 0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
